// File: rtl/seq_evt_pkg.sv
// rtl/seq_evt_pkg.sv - default sizing constants shared by the event logger files
package seq_evt_pkg;

  localparam int DEF_DEPTH     = 8;
  localparam int DEF_TS_W      = 16;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_IRQ_LEVEL = 4;

  // One extra pointer bit distinguishes full from empty when the index bits match.
  localparam int DEF_PTR_W     = $clog2(DEF_DEPTH) + 1;

endpackage

// File: rtl/seq_evt_logger_if.sv
// rtl/seq_evt_logger_if.sv - valid/ready read port carrying logged timestamps
interface seq_evt_logger_if
  import seq_evt_pkg::*;
#(
  parameter int TS_W = DEF_TS_W
);

  logic            rd_valid;
  logic            rd_ready;
  logic [TS_W-1:0] rd_data;

  // The logger drives the head entry; the host or debug bus accepts it.
  modport master (output rd_valid, output rd_data, input rd_ready);
  modport slave  (input rd_valid, input rd_data, output rd_ready);

endinterface

// File: rtl/seq_evt_fifo.sv
// rtl/seq_evt_fifo.sv - generic synchronous show-ahead FIFO with occupancy output
module seq_evt_fifo
  import seq_evt_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W     = DEF_TS_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seq_evt_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  // Flag decode from the pointers; a full FIFO may still take a push if it pops too.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    level   = wr_ptr - rd_ptr;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata   = mem[rd_ptr[AW-1:0]];
  end

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is zeroed on reset so the head reads 0 until the first push lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clear) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/seq_evt_logger.sv
// rtl/seq_evt_logger.sv - timestamps detector match pulses into a readable FIFO (optional irq: SEQ_EVT_IRQ_EN)
module seq_evt_logger
  import seq_evt_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int TS_W      = DEF_TS_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int IRQ_LEVEL = DEF_IRQ_LEVEL
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   det_pulse,
  input  logic                   clear,
  seq_evt_logger_if.master       rd,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       match_cnt,
  output logic                   overflow,
  output logic                   irq
);

  localparam int LW = $clog2(DEPTH) + 1;

  if (IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_bad_irq_level
    $error("seq_evt_logger: IRQ_LEVEL must lie in 1..DEPTH");
  end

  logic [TS_W-1:0] ts;
  logic            empty;
  logic            full;
  logic            rd_fire;
  logic            push;
  logic            pop;
  logic            drop;

  assign rd.rd_valid = !empty;

  // Accept logic: a pulse is stored unless the FIFO is full with no pop this cycle.
  always_comb begin
    rd_fire = rd.rd_valid && rd.rd_ready;
    push    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    if (!clear) begin
      pop  = rd_fire;
      push = det_pulse && (!full || rd_fire);
      drop = det_pulse && full && !rd_fire;
    end
  end

  seq_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (TS_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .wdata (ts),
    .rdata (rd.rd_data),
    .empty (empty),
    .full  (full),
    .level (level)
  );

  // Free-running cycle timestamp, wrapping naturally at its width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      ts <= '0;
    else if (clear) ts <= '0;
    else            ts <= ts + 1'b1;
  end

  // Total matches, dropped ones included; holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                           match_cnt <= '0;
    else if (clear)                                      match_cnt <= '0;
    else if (det_pulse && (match_cnt != {CNT_W{1'b1}})) match_cnt <= match_cnt + 1'b1;
  end

  // Sticky record that at least one match was lost to a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

`ifdef SEQ_EVT_IRQ_EN
  logic [LW-1:0] level_nxt;
  logic          overflow_nxt;

  // Predict the post-edge level and overflow so irq changes on the same edge as level.
  always_comb begin
    level_nxt    = level + LW'(push) - LW'(pop);
    overflow_nxt = overflow || drop;
    if (clear) begin
      level_nxt    = '0;
      overflow_nxt = 1'b0;
    end
  end

  // Level interrupt, also held while a drop is outstanding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= (int'(level_nxt) >= IRQ_LEVEL) || overflow_nxt;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_seq_evt_logger.sv
// tb/tb_seq_evt_logger.sv - table-driven scoreboard bench for seq_evt_logger
module tb_seq_evt_logger;
  import seq_evt_pkg::*;

  localparam int DEPTH     = DEF_DEPTH;
  localparam int TS_W      = DEF_TS_W;
  localparam int CNT_W     = DEF_CNT_W;
  localparam int IRQ_LEVEL = DEF_IRQ_LEVEL;
  localparam int LW        = DEF_PTR_W;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             det_pulse = 1'b0;
  logic             clear = 1'b0;
  logic [LW-1:0]    level;
  logic [CNT_W-1:0] match_cnt;
  logic             overflow;
  logic             irq;

  seq_evt_logger_if #(.TS_W(TS_W)) rd_if ();

  seq_evt_logger #(
    .DEPTH     (DEPTH),
    .TS_W      (TS_W),
    .CNT_W     (CNT_W),
    .IRQ_LEVEL (IRQ_LEVEL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .det_pulse (det_pulse),
    .clear     (clear),
    .rd        (rd_if),
    .level     (level),
    .match_cnt (match_cnt),
    .overflow  (overflow),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [TS_W-1:0] sb_q [$];
  int              m_ts;
  int              m_cnt;
  bit              m_ovf;

  typedef struct {
    logic p;
    logic r;
    logic c;
    int   n;
    int   e_level;
    int   e_cnt;
    bit   e_ovf;
    bit   e_valid;
    bit   chk_d;
    int   e_data;
  } vec_t;

  vec_t vt [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_model();
    bit exp_irq;
    chk("rd_valid", 32'(rd_if.rd_valid), 32'(sb_q.size() != 0));
    chk("level", 32'(level), 32'(sb_q.size()));
    if (sb_q.size() != 0) chk("rd_data", 32'(rd_if.rd_data), 32'(sb_q[0]));
    chk("match_cnt", 32'(match_cnt), 32'(m_cnt));
    chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef SEQ_EVT_IRQ_EN
    exp_irq = (sb_q.size() >= IRQ_LEVEL) || m_ovf;
`else
    exp_irq = 1'b0;
`endif
    chk("irq", 32'(irq), 32'(exp_irq));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ts  = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Drive one cycle of inputs at the negedge, advance the model across the posedge, check at the next negedge.
  task automatic cycle(input logic p, input logic r, input logic c);
    bit fire;
    bit accept;
    det_pulse     = p;
    rd_if.rd_ready = r;
    clear         = c;
    fire   = r && (sb_q.size() != 0);
    accept = (sb_q.size() < DEPTH) || fire;
    @(posedge clk);
    if (c) begin
      model_reset();
    end else begin
      if (fire) void'(sb_q.pop_front());
      if (p) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (accept) sb_q.push_back(TS_W'(m_ts));
        else        m_ovf = 1'b1;
      end
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
    @(negedge clk);
    check_model();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          p  r  c  n      lvl cnt      ovf v  chk data
    vt[0]  = '{1'b0, 1'b0, 1'b0, 5,     0, 0,       0, 0, 0, 0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1,     1, 1,       0, 1, 1, 5};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1,     0, 1,       0, 0, 0, 0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1,     0, 0,       0, 0, 0, 0};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 3,     0, 0,       0, 0, 0, 0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 10,    8, 10,      1, 1, 1, 3};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 8,     0, 10,      1, 0, 0, 0};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 1,     0, 0,       0, 0, 0, 0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 8,     8, 8,       0, 1, 1, 0};
    vt[9]  = '{1'b1, 1'b1, 1'b0, 1,     8, 9,       0, 1, 1, 1};
    vt[10] = '{1'b0, 1'b1, 1'b0, 7,     1, 9,       0, 1, 1, 8};
    vt[11] = '{1'b0, 1'b1, 1'b0, 1,     0, 9,       0, 0, 0, 0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 1,     0, 0,       0, 0, 0, 0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 3,     3, 3,       0, 1, 1, 0};
    vt[14] = '{1'b1, 1'b1, 1'b1, 1,     0, 0,       0, 0, 0, 0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 1,     1, 1,       0, 1, 1, 0};
    vt[16] = '{1'b0, 1'b0, 1'b1, 1,     0, 0,       0, 0, 0, 0};
    vt[17] = '{1'b1, 1'b0, 1'b0, 4,     4, 4,       0, 1, 1, 0};
    vt[18] = '{1'b0, 1'b1, 1'b0, 1,     3, 4,       0, 1, 1, 1};
    vt[19] = '{1'b0, 1'b0, 1'b1, 1,     0, 0,       0, 0, 0, 0};
    vt[20] = '{1'b1, 1'b1, 1'b0, 65538, 1, 65535,   0, 1, 1, 1};
    vt[21] = '{1'b0, 1'b0, 1'b0, 2,     1, 65535,   0, 1, 1, 1};

    rd_if.rd_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_level", 32'(level), 0);
    chk("reset_rd_valid", 32'(rd_if.rd_valid), 0);
    chk("reset_rd_data", 32'(rd_if.rd_data), 0);
    chk("reset_match_cnt", 32'(match_cnt), 0);
    chk("reset_overflow", 32'(overflow), 0);
    chk("reset_irq", 32'(irq), 0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      for (int k = 0; k < vt[i].n; k++) cycle(vt[i].p, vt[i].r, vt[i].c);
      chk($sformatf("row%0d_level", i), 32'(level), 32'(vt[i].e_level));
      chk($sformatf("row%0d_match_cnt", i), 32'(match_cnt), 32'(vt[i].e_cnt));
      chk($sformatf("row%0d_overflow", i), 32'(overflow), 32'(vt[i].e_ovf));
      chk($sformatf("row%0d_rd_valid", i), 32'(rd_if.rd_valid), 32'(vt[i].e_valid));
      if (vt[i].chk_d) chk($sformatf("row%0d_rd_data", i), 32'(rd_if.rd_data), 32'(vt[i].e_data));
`ifdef SEQ_EVT_IRQ_EN
      if (i == 17) chk("irq_at_level4", 32'(irq), 1);
      if (i == 18) chk("irq_after_pop", 32'(irq), 0);
`else
      chk($sformatf("row%0d_irq", i), 32'(irq), 0);
`endif
    end

    // Asynchronous reset in the middle of traffic drops everything at once.
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("pre_reset_level", 32'(level), 3);
    det_pulse = 1'b0;
    rd_if.rd_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_level", 32'(level), 0);
    chk("async_reset_rd_valid", 32'(rd_if.rd_valid), 0);
    chk("async_reset_rd_data", 32'(rd_if.rd_data), 0);
    chk("async_reset_match_cnt", 32'(match_cnt), 0);
    chk("async_reset_overflow", 32'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_model();
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    chk("post_reset_first_ts", 32'(rd_if.rd_data), 1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("post_reset_drained", 32'(level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_evt_logger.md
Name: seq_evt_logger

Overview:
- Downstream consumer of the serial sequence detector.
- Takes the detector's 1-cycle Mealy match pulse and stamps it with a free-running cycle timestamp.
- Buffers the timestamps in a small show-ahead FIFO and presents them on a valid/ready read port for a host or debug bus.
- Also keeps a saturating total-match counter and a sticky overflow flag.

Parameters:
DEPTH, 8, FIFO entries; power of 2, >=2
TS_W, 16, timestamp width (bits)
CNT_W, 16, match counter width (bits)
IRQ_LEVEL, 4, FIFO level at or above which irq asserts (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
det_pulse  in  1  match pulse from detector (dout); one event per high cycle
clear  in  1  synchronous clear of FIFO, counter, timestamp, overflow
rd_valid  out  1  FIFO head entry available
rd_ready  in  1  consumer accepts head entry
rd_data  out  TS_W  timestamp of oldest unread match
level  out  $clog2(DEPTH)+1  current FIFO occupancy
match_cnt  out  CNT_W  total matches seen, saturating
overflow  out  1  sticky: a match was dropped because the FIFO was full
irq  out  1  level interrupt; tied 0 unless the optional feature is compiled in

Behaviour:
- Reset (async): ts=0, FIFO empty (rd_valid=0, level=0), match_cnt=0, overflow=0, irq=0. rd_data=0 while empty after reset.
- Timestamp: ts increments by 1 every cycle and wraps modulo 2^TS_W (0xFFFF -> 0x0000).
- A det_pulse in cycle N writes the ts value of cycle N.
- Push: on det_pulse, when (!full || rd_fire).
  - A full FIFO with a simultaneous pop still accepts the push.
  - Otherwise the event is dropped and overflow <= 1.
- Pop: rd_fire = rd_valid && rd_ready. The head advances on the clock edge.
- rd_valid and rd_data are registered. rd_data holds mem[rd_ptr] (show-ahead).
- Latency: det_pulse in cycle N into an empty FIFO -> rd_valid=1 and rd_data=ts(N) in cycle N+1.
- rd_data stays stable while rd_valid && !rd_ready.
- Simultaneous push and pop on a non-empty, non-full FIFO: level unchanged.
- Simultaneous push and pop on an empty FIFO: impossible, since rd_valid=0.
- match_cnt increments on every det_pulse, including dropped ones. It saturates at 2^CNT_W-1 and does not wrap.
- Back-to-back pulses in consecutive cycles are each distinct events.
- Pointers: rd_ptr/wr_ptr are log2(DEPTH)+1 bits.
  - empty when the pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
- clear (sync):
  - Empties the FIFO and zeroes ts, match_cnt and overflow on the next edge.
  - Takes priority over any det_pulse or rd_fire in the same cycle; that pulse is neither stored nor counted.
- Reset mid-operation discards all FIFO contents immediately. No partial state survives.
- overflow clears only via reset or clear.

Optional Feature:
- Macro: SEQ_EVT_IRQ_EN.
- Defined: irq is registered, irq = (level >= IRQ_LEVEL), updated on the same edge as level. It deasserts when pops bring level below IRQ_LEVEL.
  - Also set while overflow=1.
- Undefined: irq is constant 0 and no comparator logic is present. The port list is unchanged.

Decomposition:
- Package seq_evt_pkg: default DEPTH/TS_W/CNT_W/IRQ_LEVEL constants and the ptr-width constant derived from DEPTH.
- The detector's state encoding is not needed here.
- Sub-module seq_evt_fifo: generic synchronous show-ahead FIFO.
  - Inputs: push, pop, wdata, clear.
  - Outputs: rdata, empty, full, level.
- Top level holds the ts counter, match counter, overflow/irq and push-accept logic.

Test Plan:
- Single pulse: reset, release at ts=0, pulse in cycle 5 -> next cycle rd_valid=1, rd_data=5, level=1, match_cnt=1. rd_ready=1 -> rd_valid=0, level=0.
- Fill/overflow: 10 consecutive pulses at cycles 3..12 with rd_ready=0 -> level=8, entries 3..10 readable in order, overflow=1, match_cnt=10.
- Full with simultaneous pop: fill to 8, then pulse and rd_fire together -> level stays 8, overflow stays 0, new timestamp lands at the tail.
- Wrap and saturation: run 65540 cycles, pulse at cycle 65537 -> rd_data=1. Force match_cnt to 0xFFFE, send 3 pulses -> match_cnt=0xFFFF.
- Clear priority: FIFO holding 3 entries, clear and det_pulse in the same cycle -> next cycle level=0, match_cnt=0, overflow=0, ts=0, and the pulse is not stored.
- IRQ (SEQ_EVT_IRQ_EN): push 4 entries -> irq=1 on the edge where level becomes 4. Pop 1 -> irq=0. Without the macro, irq=0 throughout.
